// File: rtl/i2cs_regacc_if.sv
// Register-file access bus between the I2C register sequencer and the register file.
// Single outstanding request; req/addr/wdata held until ack, rdata valid with ack.
// master = sequencer side, slave = register-file side.
interface i2cs_regacc_if #(
  parameter int ADDR_W = 8
);
  logic              reg_req;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_ack;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_req, reg_wr, reg_addr, reg_wdata,
    input  reg_ack, reg_rdata
  );

  modport slave (
    input  reg_req, reg_wr, reg_addr, reg_wdata,
    output reg_ack, reg_rdata
  );
endinterface

// File: rtl/i2cs_regacc.sv
// Register-access sequencer: I2C write bytes -> pointer + register writes; prefetches one read byte.
// Latency: register request issued the cycle after a byte is buffered / a prefetch becomes due.
// Backpressure: rx_full/tx_empty stretch SCL; req/addr/data held until reg_ack.
// Optional macro I2CS_REGACC_WPROT_EN: writes at ptr >= WP_BASE are silently skipped.
module i2cs_regacc #(
  parameter int ADDR_W = 8
`ifdef I2CS_REGACC_WPROT_EN
  , parameter logic [7:0] WP_BASE = 8'hF0
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2cs_en,
  input  logic        i2cs_work,
  input  logic        i2cs_rw,
  input  logic        start_flag,
  input  logic        stop_flag,
  input  logic [7:0]  i2cs_rx,
  input  logic        i2cs_rx_wen,
  input  logic        i2cs_tx_ren,
  output logic        rx_full,
  output logic        tx_empty,
  output logic [7:0]  i2cs_tx_data,
  i2cs_regacc_if.master bus,
  input  logic        ovr_clr,
  output logic        ovr_intr
);

  typedef enum logic [1:0] {IDLE, WREQ, RREQ} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              first_byte_q, first_byte_d;
  logic [7:0]        wbuf_q, wbuf_d;
  logic              wbuf_vld_q, wbuf_vld_d;
  logic [7:0]        tx_buf_q, tx_buf_d;
  logic              tx_vld_q, tx_vld_d;
  logic              cancel_q, cancel_d;
  logic              ovr_q, ovr_d;
  logic              reg_req_q, reg_req_d;
  logic              reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;

  logic w_done;      // write access finished this cycle (acked or skipped)
  logic r_done;      // read access acked this cycle
  logic ptr_load;    // first write byte after START is the register pointer
  logic rx_data;     // write byte destined for the register file
  logic tx_adv;      // master consumed the prefetched byte
  logic rd_due;      // slave is in a read data phase and needs a byte
  logic flush_evt;   // anything that invalidates a prefetched byte
  logic wp_hit;      // current pointer is write-protected

  assign r_done    = (state_q == RREQ) && bus.reg_ack;
  assign ptr_load  = i2cs_rx_wen && first_byte_q;
  assign rx_data   = i2cs_rx_wen && !first_byte_q;
  assign tx_adv    = i2cs_tx_ren && tx_vld_q;
  assign rd_due    = i2cs_work && i2cs_rw && !tx_vld_q && i2cs_en && !first_byte_q;
  assign flush_evt = start_flag || stop_flag || !i2cs_en;

`ifdef I2CS_REGACC_WPROT_EN
  logic [7:0] ptr_ext;

  // Zero-extend the pointer so the comparison is against the full 8-bit base
  always_comb begin
    ptr_ext = '0;
    ptr_ext[ADDR_W-1:0] = ptr_q;
  end

  assign wp_hit = (ptr_ext >= WP_BASE);
  // A protected write enters WREQ with no request and retires one cycle later
  assign w_done = (state_q == WREQ) && (!reg_req_q || bus.reg_ack);
`else
  assign wp_hit = 1'b0;
  assign w_done = (state_q == WREQ) && bus.reg_ack;
`endif

  // Access arbiter: pending write beats prefetch; request held until ack, then one idle cycle
  always_comb begin
    state_d     = state_q;
    reg_req_d   = reg_req_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    case (state_q)
      IDLE: begin
        if (wbuf_vld_q) begin
          state_d     = WREQ;
          reg_req_d   = !wp_hit;
          reg_wr_d    = 1'b1;
          reg_addr_d  = ptr_q;
          reg_wdata_d = wbuf_q;
        end else if (rd_due) begin
          state_d    = RREQ;
          reg_req_d  = 1'b1;
          reg_wr_d   = 1'b0;
          reg_addr_d = ptr_q;
        end
      end
      WREQ: begin
        if (w_done) begin
          state_d   = IDLE;
          reg_req_d = 1'b0;
        end
      end
      RREQ: begin
        if (r_done) begin
          state_d   = IDLE;
          reg_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        reg_req_d = 1'b0;
      end
    endcase
  end

  // Pointer, write buffer, prefetch buffer and overrun tracking
  always_comb begin
    ptr_d        = ptr_q;
    first_byte_d = first_byte_q;
    wbuf_d       = wbuf_q;
    wbuf_vld_d   = wbuf_vld_q;
    tx_buf_d     = tx_buf_q;
    tx_vld_d     = tx_vld_q;
    cancel_d     = cancel_q;
    ovr_d        = ovr_q;

    // A pointer load wins; otherwise write retire and read advance each step once
    if (ptr_load) begin
      ptr_d = i2cs_rx[ADDR_W-1:0];
    end else begin
      ptr_d = ptr_q + ADDR_W'(w_done) + ADDR_W'(tx_adv);
    end

    // Read transfers carry no pointer byte, so the read direction ends pointer capture
    if (ptr_load || (i2cs_work && i2cs_rw)) first_byte_d = 1'b0;
    if (start_flag)     first_byte_d = 1'b1;
    else if (stop_flag) first_byte_d = 1'b0;
    if (!i2cs_en)       first_byte_d = 1'b0;

    // A byte arriving as the previous write retires is accepted, not an overrun
    if (w_done) wbuf_vld_d = 1'b0;
    if (rx_data && (!wbuf_vld_q || w_done)) begin
      wbuf_d     = i2cs_rx;
      wbuf_vld_d = 1'b1;
    end
    if (!i2cs_en) wbuf_vld_d = 1'b0;

    if (ovr_clr) begin
      ovr_d = 1'b0;
    end else if (rx_data && wbuf_vld_q && !w_done) begin
      ovr_d = 1'b1;
    end

    // Read data lands first, then START/STOP/disable clear it, so a stop beats late rdata
    if (tx_adv) tx_vld_d = 1'b0;
    if (state_q == RREQ) begin
      if (bus.reg_ack) begin
        cancel_d = 1'b0;
        if (!cancel_q) begin
          tx_buf_d = bus.reg_rdata;
          tx_vld_d = 1'b1;
        end
      end else if (flush_evt) begin
        cancel_d = 1'b1;
      end
    end
    if (flush_evt) tx_vld_d = 1'b0;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      first_byte_q <= 1'b0;
      wbuf_q       <= '0;
      wbuf_vld_q   <= 1'b0;
      tx_buf_q     <= '0;
      tx_vld_q     <= 1'b0;
      cancel_q     <= 1'b0;
      ovr_q        <= 1'b0;
      reg_req_q    <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      first_byte_q <= first_byte_d;
      wbuf_q       <= wbuf_d;
      wbuf_vld_q   <= wbuf_vld_d;
      tx_buf_q     <= tx_buf_d;
      tx_vld_q     <= tx_vld_d;
      cancel_q     <= cancel_d;
      ovr_q        <= ovr_d;
      reg_req_q    <= reg_req_d;
      reg_wr_q     <= reg_wr_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  assign rx_full       = wbuf_vld_q;
  assign tx_empty      = !tx_vld_q;
  assign i2cs_tx_data  = tx_vld_q ? tx_buf_q : 8'hFF;
  assign ovr_intr      = ovr_q;
  assign bus.reg_req   = reg_req_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_i2cs_regacc.sv
// Bench for i2cs_regacc: table of write/readback transactions plus hand sequences
// for pointer-then-read, overrun, stop-cancelled prefetch and (optionally) write protect.
// A register-file responder with programmable ack latency checks accesses against a queue.
`timescale 1ns/1ps
module tb_i2cs_regacc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i2cs_en, i2cs_work, i2cs_rw, start_flag, stop_flag;
  logic [7:0] i2cs_rx;
  logic       i2cs_rx_wen, i2cs_tx_ren;
  logic       rx_full, tx_empty;
  logic [7:0] i2cs_tx_data;
  logic       ovr_clr, ovr_intr;

  always #5 clk = ~clk;

  i2cs_regacc_if #(.ADDR_W(8)) bus ();

  i2cs_regacc #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i2cs_en(i2cs_en), .i2cs_work(i2cs_work),
    .i2cs_rw(i2cs_rw), .start_flag(start_flag), .stop_flag(stop_flag),
    .i2cs_rx(i2cs_rx), .i2cs_rx_wen(i2cs_rx_wen), .i2cs_tx_ren(i2cs_tx_ren),
    .rx_full(rx_full), .tx_empty(tx_empty), .i2cs_tx_data(i2cs_tx_data),
    .bus(bus), .ovr_clr(ovr_clr), .ovr_intr(ovr_intr)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct {
    logic [7:0] ptr;
    int         n;
    logic [7:0] d0, d1;
    logic [7:0] a0, a1;
    int         lat;
    logic [7:0] nxt;
  } wvec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  acc_t       exp_q[$];
  logic [7:0] mem[256];
  int         ack_lat = 0;
  int         wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Register-file model: acks after ack_lat waiting cycles, checks each access on ack
  always @(negedge clk) begin : responder
    acc_t e;
    if (!rst_n) begin
      bus.reg_ack   = 1'b0;
      bus.reg_rdata = 8'h00;
      wait_cnt      = 0;
    end else if (bus.reg_req && !bus.reg_ack) begin
      if (wait_cnt >= ack_lat) begin
        wait_cnt    = 0;
        bus.reg_ack = 1'b1;
        if (bus.reg_wr) mem[bus.reg_addr] = bus.reg_wdata;
        else            bus.reg_rdata     = mem[bus.reg_addr];
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_access: got wr=%0b addr=%0h wdata=%0h want none",
                   bus.reg_wr, bus.reg_addr, bus.reg_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("bus_access",
              {15'b0, bus.reg_wr, bus.reg_addr, (bus.reg_wr ? bus.reg_wdata : 8'h00)},
              {15'b0, e.wr, e.addr, (e.wr ? e.wdata : 8'h00)});
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      bus.reg_ack = 1'b0;
      wait_cnt    = 0;
    end
  end

  task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d);
    acc_t t;
    t.wr = wr; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  // cond: 0 tx byte ready, 1 scoreboard drained, 2 rx buffer free, 3 request raised
  task automatic wait_for(input int cond, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      case (cond)
        0:       ok = !tx_empty;
        1:       ok = (exp_q.size() == 0);
        2:       ok = !rx_full;
        3:       ok = bus.reg_req;
        default: ok = 1'b1;
      endcase
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: condition %0d not reached, want reached", name, cond);
    end
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(negedge clk); i2cs_rx = b; i2cs_rx_wen = 1'b1;
    @(negedge clk); i2cs_rx_wen = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk); start_flag = 1'b1;
    @(negedge clk); start_flag = 1'b0;
  endtask

  task automatic do_stop;
    @(negedge clk); stop_flag = 1'b1; i2cs_work = 1'b0; i2cs_rw = 1'b0;
    @(negedge clk); stop_flag = 1'b0;
  endtask

  task automatic pulse_ren;
    @(negedge clk); i2cs_tx_ren = 1'b1;
    @(negedge clk); i2cs_tx_ren = 1'b0;
  endtask

  task automatic wr_xfer(input logic [7:0] p, input int n,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] a0, input logic [7:0] a1);
    i2cs_work = 1'b1; i2cs_rw = 1'b0;
    pulse_start;
    pulse_rx(p);
    wait_for(2, "rx_free0");
    push(1'b1, a0, d0);
    pulse_rx(d0);
    if (n > 1) begin
      wait_for(2, "rx_free1");
      push(1'b1, a1, d1);
      pulse_rx(d1);
    end
    wait_for(1, "wr_done");
    wait_for(2, "rx_clear");
    do_stop;
  endtask

  // (Repeated) START into a read transfer; expects a prefetch at address a
  task automatic rd_begin(input logic [7:0] a);
    pulse_start;
    push(1'b0, a, 8'h00);
    i2cs_work = 1'b1; i2cs_rw = 1'b1;
    wait_for(0, "tx_fill");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t      tbl[4];
    logic [7:0] ev;

    tbl[0] = '{8'h10, 2, 8'hAA, 8'h55, 8'h10, 8'h11, 1, 8'h12};
    tbl[1] = '{8'hFF, 2, 8'h77, 8'h88, 8'hFF, 8'h00, 0, 8'h01};
    tbl[2] = '{8'h40, 1, 8'h5A, 8'h00, 8'h40, 8'h00, 2, 8'h41};
    tbl[3] = '{8'h7F, 2, 8'h01, 8'h02, 8'h7F, 8'h80, 0, 8'h81};

    for (int i = 0; i < 256; i++) mem[i] = 8'(~i);
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'h4D;
    mem[8'h22] = 8'h66;

    rst_n = 1'b0; i2cs_en = 1'b1; i2cs_work = 1'b0; i2cs_rw = 1'b0;
    start_flag = 1'b0; stop_flag = 1'b0; i2cs_rx = 8'h00;
    i2cs_rx_wen = 1'b0; i2cs_tx_ren = 1'b0; ovr_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rx_full", rx_full, 0);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_tx_data", i2cs_tx_data, 8'hFF);
    chk("rst_reg_req", bus.reg_req, 0);
    chk("rst_reg_wr", bus.reg_wr, 0);
    chk("rst_reg_addr", bus.reg_addr, 0);
    chk("rst_reg_wdata", bus.reg_wdata, 0);
    chk("rst_ovr_intr", ovr_intr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: write burst, then read back at the post-increment pointer
    foreach (tbl[k]) begin
      ack_lat = tbl[k].lat;
      wr_xfer(tbl[k].ptr, tbl[k].n, tbl[k].d0, tbl[k].d1, tbl[k].a0, tbl[k].a1);
      chk("wr_rx_full", rx_full, 0);
      chk("wr_ovr_intr", ovr_intr, 0);
      rd_begin(tbl[k].nxt);
      ev = ~tbl[k].nxt;
      chk("rd_tx_data", i2cs_tx_data, ev);
      do_stop;
      @(negedge clk);
      chk("stop_tx_empty", tx_empty, 1);
      chk("stop_tx_data", i2cs_tx_data, 8'hFF);
    end

    // Pointer write, repeated START, read and advance
    ack_lat = 1;
    i2cs_work = 1'b1; i2cs_rw = 1'b0;
    pulse_start;
    pulse_rx(8'h20);
    rd_begin(8'h20);
    chk("rd20_tx_empty", tx_empty, 0);
    chk("rd20_tx_data", i2cs_tx_data, 8'h3C);
    push(1'b0, 8'h21, 8'h00);
    pulse_ren;
    chk("ren_tx_empty", tx_empty, 1);
    wait_for(0, "tx_fill21");
    chk("rd21_tx_data", i2cs_tx_data, 8'h4D);

    // STOP while the read request is outstanding: late rdata must be discarded
    ack_lat = 3;
    push(1'b0, 8'h22, 8'h00);
    pulse_ren;
    wait_for(3, "rreq22");
    do_stop;
    wait_for(1, "rd22_ack");
    repeat (3) @(negedge clk);
    chk("cancel_tx_empty", tx_empty, 1);
    chk("cancel_tx_data", i2cs_tx_data, 8'hFF);

    // tx_ren with nothing prefetched must not move the pointer
    pulse_ren;
    rd_begin(8'h22);
    chk("rd22_tx_data", i2cs_tx_data, 8'h66);
    do_stop;

    // Overrun while a write is stalled on ack
    ack_lat = 10;
    chk("pre_ovr_intr", ovr_intr, 0);
    i2cs_work = 1'b1; i2cs_rw = 1'b0;
    pulse_start;
    pulse_rx(8'h30);
    push(1'b1, 8'h30, 8'hA1);
    pulse_rx(8'hA1);
    repeat (2) @(negedge clk);
    pulse_rx(8'hB2);
    chk("ovr_rx_full", rx_full, 1);
    chk("ovr_intr_set", ovr_intr, 1);
    wait_for(1, "ovr_wr");
    repeat (6) @(negedge clk);
    chk("ovr_rx_full_clr", rx_full, 0);
    chk("ovr_intr_sticky", ovr_intr, 1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    chk("ovr_intr_clr", ovr_intr, 0);
    do_stop;

`ifdef I2CS_REGACC_WPROT_EN
    // Protected address: no bus access, pointer still advances
    ack_lat = 0;
    i2cs_work = 1'b1; i2cs_rw = 1'b0;
    pulse_start;
    pulse_rx(8'hF2);
    pulse_rx(8'h11);
    repeat (2) @(negedge clk);
    chk("wp_rx_full", rx_full, 0);
    do_stop;
    rd_begin(8'hF3);
    chk("wp_rd_data", i2cs_tx_data, 8'h0C);
    do_stop;
`endif

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
